// File: rtl/carwash_pkg.sv
// carwash_pkg: shared types and default timing constants for the carwash
// timer datapath.
//   timer_state_t : one-hot timer FSM state (HALT, IDLE, RUN, DONE)
//   *_DEF         : default tick divider and spray/rinse durations
package carwash_pkg;

  typedef enum logic [3:0] {
    HALT = 4'b0001,
    IDLE = 4'b0010,
    RUN  = 4'b0100,
    DONE = 4'b1000
  } timer_state_t;

  localparam int TICK_DIV_DEF = 1000;
  localparam int T1_TICKS_DEF = 30;
  localparam int T2_TICKS_DEF = 20;

endpackage

// File: rtl/carwash_timers_if.sv
// carwash_timers_if: controller <-> timer datapath signals.
//   CLRT1/CLRT2 : clear spray/rinse timer (held high = held cleared)
//   FREEZE      : emergency hold of running timers
//   T1DONE/T2DONE : sticky expiry flags back to the controller
//   master = controller FSM side, slave = timer datapath side
interface carwash_timers_if;
  logic CLRT1;
  logic CLRT2;
  logic FREEZE;
  logic T1DONE;
  logic T2DONE;

  modport master (output CLRT1, output CLRT2, output FREEZE,
                  input  T1DONE, input T2DONE);
  modport slave  (input  CLRT1, input CLRT2, input FREEZE,
                  output T1DONE, output T2DONE);
endinterface

// File: rtl/carwash_timer.sv
// carwash_timer: one cycle-accurate timer expiring after N counting edges.
//   clk    : rising-edge clock
//   CLR    : asynchronous active-high reset (back to HALT)
//   CLRT   : clear, priority over everything but CLR; held = held cleared
//   FREEZE : holds the count while in RUN
//   DONE   : registered, sticky expiry flag
module carwash_timer
  import carwash_pkg::*;
#(
  parameter int N     = 12,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic CLR,
  input  logic CLRT,
  input  logic FREEZE,
  output logic DONE
);

  if (N < 1) begin : g_bad_n
    $error("carwash_timer: N must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_w
    $error("carwash_timer: CNT_W must be >= 1");
  end
  if ($clog2(N + 1) > CNT_W) begin : g_bad_fit
    $error("carwash_timer: N does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] NV  = CNT_W'(N);
  localparam logic [CNT_W-1:0] NM1 = CNT_W'(N - 1);

  timer_state_t     state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state <= HALT;
      cnt   <= '0;
      DONE  <= 1'b0;
    end else if (CLRT) begin
      state <= IDLE;
      cnt   <= '0;
      DONE  <= 1'b0;
    end else begin
      unique case (state)
        HALT: ;
        // The IDLE->RUN edge is itself counting edge 1, so N==1 expires here.
        IDLE: begin
          if (N == 1) begin
            state <= carwash_pkg::DONE;
            cnt   <= NV;
            DONE  <= 1'b1;
          end else begin
            state <= RUN;
            cnt   <= CNT_W'(1);
          end
        end
        RUN: begin
          if (!FREEZE) begin
            if (cnt == NM1) begin
              state <= carwash_pkg::DONE;
              cnt   <= NV;
              DONE  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        carwash_pkg::DONE: ;
        default: begin
          state <= HALT;
          cnt   <= '0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/carwash_timers.sv
// carwash_timers: spray (T1) and rinse (T2) timers beside the carwash FSM.
//   clk : rising-edge clock
//   CLR : asynchronous active-high reset
//   bus : slave side of carwash_timers_if (CLRT1/CLRT2/FREEZE in,
//         T1DONE/T2DONE out)
module carwash_timers
  import carwash_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int T1_TICKS = T1_TICKS_DEF,
  parameter int T2_TICKS = T2_TICKS_DEF,
  parameter int CNT_W    = 32
) (
  input  logic           clk,
  input  logic           CLR,
  carwash_timers_if.slave bus
);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("carwash_timers: TICK_DIV must be >= 1");
  end
  if (T1_TICKS < 1) begin : g_bad_t1
    $error("carwash_timers: T1_TICKS must be >= 1");
  end
  if (T2_TICKS < 1) begin : g_bad_t2
    $error("carwash_timers: T2_TICKS must be >= 1");
  end

  localparam int N1 = TICK_DIV * T1_TICKS;
  localparam int N2 = TICK_DIV * T2_TICKS;

  carwash_timer #(.N(N1), .CNT_W(CNT_W)) u_t1 (
    .clk    (clk),
    .CLR    (CLR),
    .CLRT   (bus.CLRT1),
    .FREEZE (bus.FREEZE),
    .DONE   (bus.T1DONE)
  );

  carwash_timer #(.N(N2), .CNT_W(CNT_W)) u_t2 (
    .clk    (clk),
    .CLR    (CLR),
    .CLRT   (bus.CLRT2),
    .FREEZE (bus.FREEZE),
    .DONE   (bus.T2DONE)
  );

endmodule

// File: doc/carwash_timers.md
# carwash_timers

Timer datapath for the carwash controller. It holds two independent cycle-accurate timers: T1 is the spray timer and T2 is the rinse timer. The controller FSM clears each timer with `CLRT1`/`CLRT2` and reads expiry back on `T1DONE`/`T2DONE`. The block sits beside the FSM, receiving its clear outputs and driving its done inputs, so a wash sequence can be closed in simulation and in hardware.

## Interface
Parameters:
- `TICK_DIV`, 1000: clk cycles per timer tick. Must be ≥1.
- `T1_TICKS`, 30: spray duration in ticks. Must be ≥1.
- `T2_TICKS`, 20: rinse duration in ticks. Must be ≥1.
- `CNT_W`, 32: width of the internal cycle counter. `TICK_DIV*max(T1_TICKS,T2_TICKS)` must fit in it.

Ports:
- `clk` in 1: single clock. Rising-edge.
- `CLR` in 1: reset, asynchronous, active-high.
- `CLRT1` in 1: clear the spray timer. Held high means held cleared.
- `CLRT2` in 1: clear the rinse timer. Same semantics as `CLRT1`.
- `FREEZE` in 1: emergency hold. While high, both running timers hold their count.
- `T1DONE` out 1: spray time expired. Registered, sticky until cleared.
- `T2DONE` out 1: rinse time expired. Registered, sticky until cleared.

## Operation
- The two timers are identical instances that differ only in duration: N1 = `TICK_DIV*T1_TICKS` and N2 = `TICK_DIV*T2_TICKS` clk cycles.
- Each timer FSM is one-hot with four states: HALT, IDLE, RUN, DONE.
  - HALT: the state after reset. The timer does not count. `CLRTx`=1 → IDLE.
  - IDLE: counter is 0, done=0. `CLRTx`=0 → RUN, and that edge counts as cycle 1.
  - RUN: counter increments on each edge where `CLRTx`=0 and `FREEZE`=0. The edge where the counter reaches N → DONE.
  - DONE: done=1. The timer stays here while `CLRTx`=0.
- `CLRTx`=1 takes priority in every state: the next state is IDLE, the counter is zeroed and done=0.
- `FREEZE`=1 in RUN holds the counter and state. It has no effect in HALT, IDLE or DONE, and does not override `CLRTx`.
- The count saturates at N; there is no wrap-around.
- Counter width is `CNT_W` bits, unsigned. The compare is counter == N-1 when incrementing, so DONE is entered on the Nth counting edge.

## Timing
- Reset values: `T1DONE`=0, `T2DONE`=0, both timers in HALT, counters 0.
- Reset may assert mid-run. The effect is immediate and asynchronous: done drops without waiting for a clock edge, and a new clear pulse is needed before the timer runs again.
- Latency:
  - Let `CLRTx` be sampled low first at edge e. `TxDONE` is then high after edge e+N-1 (N counting edges, e included).
  - With `FREEZE` asserted for F of those edges, done rises after edge e+N-1+F.
- A clear asserted at edge c drops done after edge c.
- Simultaneous events:
  - A clear on the same edge as the final count: clear wins, done stays 0.
  - `FREEZE` on the final edge: the count is held and DONE is entered on the next unfrozen edge.
- Interaction with the FSM sequence:
  - Dropping `CLRT1` starts T1, which runs through the spray states.
  - The `CLRT1` pulse in the soap state restarts T1 for the final spray.
  - The stale `T1DONE` present on entry to the soap state is removed one cycle later by that clear. The FSM does not sample `T1DONE` in that state.

## Structure
- Package `carwash_pkg`:
  - `timer_state_t`, a one-hot 4-bit enum: HALT, IDLE, RUN, DONE.
  - Default constants `TICK_DIV_DEF`, `T1_TICKS_DEF`, `T2_TICKS_DEF`.
- Sub-module `carwash_timer`:
  - Parameters `N` and `CNT_W`.
  - Ports `clk`, `CLR`, `CLRT`, `FREEZE`, `DONE`.
  - Instantiated twice by `carwash_timers`.
- Elaboration-time assertions check that all parameters are ≥1 and that N fits in `CNT_W` bits.

## Test plan
All scenarios use `TICK_DIV`=4, `T1_TICKS`=3 (N1=12) and `T2_TICKS`=5 (N2=20).
- Reset, then hold `CLRT1`=`CLRT2`=0 for 50 cycles → both done outputs stay 0 (HALT).
- `CLRT1` pulses for 1 cycle, then drops before edge e → `T1DONE` rises after edge e+11, stays high for 30 more cycles, then a `CLRT1` pulse drops it the next edge.
- Same start, with `FREEZE` high for 5 edges mid-run → `T1DONE` rises after edge e+16. `T2DONE` is unaffected and stays 0 because T2 was never cleared.
- Run a full wash sequence against `carwash_fsm` (TOKEN, START) → spray for 12 cycles, soap/rinse for 20 cycles, final spray for 12 cycles, then return to idle with both done outputs 0 after the next `CLRT1`.
- `CLRT2` is asserted exactly on the 20th counting edge → `T2DONE` stays 0 and the counter reads 0.
- Async `CLR` pulses for half a cycle while T1 is in DONE → `T1DONE` drops before the next edge, then re-arms only after a `CLRT1` pulse.
